// File: rtl/lut_pkg.sv
// Shared definitions for the LUT mux sweeper: FSM state encodings and the
// table-width helper used to size ports from the select width.
package lut_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Table width for n select inputs (2**n).
  function automatic int tw(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_mux_n.sv
// Purely combinational 2**N_IN:1 multiplexer; bit sel of data appears on out.
module lut_mux_n
  import lut_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int TW  = tw(N_IN)
) (
  input  logic [TW-1:0]   data,
  input  logic [N_IN-1:0] sel,
  output logic            out
);

  assign out = data[sel];

endmodule

// File: rtl/lut_mux_sweeper.sv
// Programmable truth-table evaluator with a built-in sweep engine.
// A TW-bit table drives a direct-path mux (registered to y) and a second mux
// that the sweep FSM walks over every input combination, capturing the full
// output column into sweep_result.
// Optional build macro: LUT_CHECK_EN adds exp_data/mismatch, comparing the
// captured column with an expected column at the end of every sweep.
module lut_mux_sweeper
  import lut_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int TW  = tw(N_IN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [TW-1:0]   cfg_data,
  input  logic [N_IN-1:0] sel,
  output logic            y,
  input  logic            sweep_start,
  output logic            busy,
  output logic            done,
  output logic [N_IN-1:0] sweep_idx,
  output logic [TW-1:0]   sweep_result
`ifdef LUT_CHECK_EN
  ,
  input  logic [TW-1:0]   exp_data,
  output logic            mismatch
`endif
);

  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);

  logic [1:0]    state;
  logic [TW-1:0] lut_table;
  logic          direct_bit;
  logic          sweep_bit;
  logic [TW-1:0] capture_next;

  lut_mux_n #(.N_IN(N_IN)) u_mux_direct (
    .data (lut_table),
    .sel  (sel),
    .out  (direct_bit)
  );

  lut_mux_n #(.N_IN(N_IN)) u_mux_sweep (
    .data (lut_table),
    .sel  (sweep_idx),
    .out  (sweep_bit)
  );

  // Status outputs decode straight from the state register so reset clears them at once.
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Column with the current combination's bit inserted; also feeds the end-of-sweep compare.
  always_comb begin
    capture_next            = sweep_result;
    capture_next[sweep_idx] = sweep_bit;
  end

  // Table register: writable only while idle so a running sweep sees a stable table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_table <= '0;
    end else if (cfg_we && (state == ST_IDLE)) begin
      lut_table <= cfg_data;
    end
  end

  // Direct path: one-cycle registered lookup, active in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= 1'b0;
    end else begin
      y <= direct_bit;
    end
  end

  // Sweep FSM, index counter and capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sweep_idx    <= '0;
      sweep_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sweep_start) begin
            state        <= ST_RUN;
            sweep_idx    <= '0;
            sweep_result <= '0;
          end
        end
        ST_RUN: begin
          sweep_result <= capture_next;
          if (sweep_idx == IDX_LAST) begin
            sweep_idx <= '0;
            state     <= ST_DONE;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LUT_CHECK_EN
  // Compare verdict: set on the final capture edge, cleared when a new sweep starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else if ((state == ST_IDLE) && sweep_start) begin
      mismatch <= 1'b0;
    end else if ((state == ST_RUN) && (sweep_idx == IDX_LAST)) begin
      mismatch <= (capture_next != exp_data);
    end
  end
`endif

endmodule

// File: tb/tb_lut_mux_sweeper.sv
// Directed testbench for lut_mux_sweeper at N_IN = 3, 2 and 1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lut_mux_sweeper;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // N_IN = 3 instance signals
  logic       we3 = 0, st3 = 0;
  logic [7:0] cd3 = '0;
  logic [2:0] sel3 = '0;
  logic       y3, busy3, done3;
  logic [2:0] idx3;
  logic [7:0] res3;
  // N_IN = 2 instance signals
  logic       we2 = 0, st2 = 0;
  logic [3:0] cd2 = '0;
  logic [1:0] sel2 = '0;
  logic       y2, busy2, done2;
  logic [1:0] idx2;
  logic [3:0] res2;
  // N_IN = 1 instance signals
  logic       we1 = 0, st1 = 0;
  logic [1:0] cd1 = '0;
  logic [0:0] sel1 = '0;
  logic       y1, busy1, done1;
  logic [0:0] idx1;
  logic [1:0] res1;
`ifdef LUT_CHECK_EN
  logic [7:0] exp3 = '0;
  logic [3:0] exp2 = '0;
  logic [1:0] exp1 = '0;
  logic       mm3, mm2, mm1;
`endif

  lut_mux_sweeper #(.N_IN(3)) u_dut3 (
    .clk(clk), .reset(reset), .cfg_we(we3), .cfg_data(cd3), .sel(sel3), .y(y3),
    .sweep_start(st3), .busy(busy3), .done(done3), .sweep_idx(idx3), .sweep_result(res3)
`ifdef LUT_CHECK_EN
    , .exp_data(exp3), .mismatch(mm3)
`endif
  );

  lut_mux_sweeper #(.N_IN(2)) u_dut2 (
    .clk(clk), .reset(reset), .cfg_we(we2), .cfg_data(cd2), .sel(sel2), .y(y2),
    .sweep_start(st2), .busy(busy2), .done(done2), .sweep_idx(idx2), .sweep_result(res2)
`ifdef LUT_CHECK_EN
    , .exp_data(exp2), .mismatch(mm2)
`endif
  );

  lut_mux_sweeper #(.N_IN(1)) u_dut1 (
    .clk(clk), .reset(reset), .cfg_we(we1), .cfg_data(cd1), .sel(sel1), .y(y1),
    .sweep_start(st1), .busy(busy1), .done(done1), .sweep_idx(idx1), .sweep_result(res1)
`ifdef LUT_CHECK_EN
    , .exp_data(exp1), .mismatch(mm1)
`endif
  );

  // Count done pulses of the N_IN = 3 instance.
  int done3_cnt = 0;
  always @(negedge clk) if (done3) done3_cnt <= done3_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  int done_seen;
  int base_done;

  initial begin
    // Reset state while reset is held
    #3;
    chk("rst_y", y3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_idx", idx3, 0);
    chk("rst_res", res3, 0);
    tick();
    reset = 1'b0;

    // Load XOR3 table and exercise the direct path
    we3 = 1; cd3 = 8'h96;
    tick();
    we3 = 0;
    sel3 = 3'b011; tick(); chk("y_sel011", y3, 0);
    sel3 = 3'b111; tick(); chk("y_sel111", y3, 1);
    sel3 = 3'b100; tick(); chk("y_sel100", y3, 1);

    // Full sweep: 8 RUN cycles, done after the 9th edge counting the start edge
    st3 = 1;
    tick();
    st3 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sw_busy", busy3, 1);
      chk("sw_idx", idx3, i);
      chk("sw_done_lo", done3, 0);
      tick();
    end
    chk("sw_done", done3, 1);
    chk("sw_busy_off", busy3, 0);
    chk("sw_res", res3, 8'h96);
    chk("sw_idx_wrap", idx3, 0);
    tick();
    chk("sw_done_1cyc", done3, 0);
    tick(); tick();
    chk("sw_res_hold", res3, 8'h96);

    // Ignored write and restart while busy (and while done)
    base_done = done3_cnt;
    st3 = 1;
    tick();
    we3 = 1; cd3 = 8'hFF;
    for (int i = 0; i < 7; i++) tick();
    chk("ign_busy_last", busy3, 1);
    tick();
    chk("ign_done", done3, 1);
    tick();
    we3 = 0; st3 = 0;
    chk("ign_idle", busy3, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("ign_single_done", done3_cnt - base_done, 1);
    chk("ign_res", res3, 8'h96);
    sel3 = 3'b000; tick(); tick();
    chk("ign_table_bit0", y3, 0);
    sel3 = 3'b111; tick(); tick();
    chk("ign_table_bit7", y3, 1);

    // Reset in the middle of a sweep
    st3 = 1;
    tick();
    st3 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_idx4", idx3, 4);
    chk("mid_partial", res3, 8'h06);
    base_done = done3_cnt;
    #2 reset = 1;
    #1;
    chk("mid_busy", busy3, 0);
    chk("mid_res", res3, 0);
    chk("mid_y", y3, 0);
    chk("mid_idx", idx3, 0);
    tick();
    reset = 0;
    tick();
    chk("mid_table_zero", y3, 0);
    for (int i = 0; i < 12; i++) tick();
    chk("mid_no_done", done3_cnt - base_done, 0);
    st3 = 1; tick(); st3 = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_resweep_done", done3, 1);
    chk("mid_resweep_res", res3, 8'h00);
    tick();

    // N_IN = 2: AND2 table
    we2 = 1; cd2 = 4'b1000; tick(); we2 = 0;
    st2 = 1; tick(); st2 = 0;
    busy_cnt = 0; done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy2) busy_cnt++;
      if (done2) done_seen++;
      tick();
    end
    chk("n2_busy_cycles", busy_cnt, 4);
    chk("n2_done_count", done_seen, 1);
    chk("n2_res", res2, 4'h8);
    // Simultaneous write and start: sweep sees the new table
    we2 = 1; cd2 = 4'b0110; st2 = 1; tick(); we2 = 0; st2 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("n2_wr_start_done", done2, 1);
    chk("n2_wr_start_res", res2, 4'h6);
    tick();

    // N_IN = 1: table 2'b10 makes y follow sel
    we1 = 1; cd1 = 2'b10; tick(); we1 = 0;
    sel1 = 1'b0; tick(); chk("n1_y0", y1, 0);
    sel1 = 1'b1; tick(); chk("n1_y1", y1, 1);
    sel1 = 1'b0; tick(); chk("n1_y0b", y1, 0);
    st1 = 1; tick(); st1 = 0;
    chk("n1_busy_c0", busy1, 1);
    tick();
    chk("n1_busy_c1", busy1, 1);
    tick();
    chk("n1_done", done1, 1);
    chk("n1_res", res1, 2'b10);
    tick();

`ifdef LUT_CHECK_EN
    we3 = 1; cd3 = 8'h96; tick(); we3 = 0;
    exp3 = 8'h96;
    st3 = 1; tick(); st3 = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("chk_done_a", done3, 1);
    chk("chk_match", mm3, 0);
    tick();
    exp3 = 8'h97;
    st3 = 1; tick(); st3 = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("chk_done_b", done3, 1);
    chk("chk_mismatch", mm3, 1);
    tick(); tick();
    chk("chk_mismatch_hold", mm3, 1);
    st3 = 1; tick(); st3 = 0;
    chk("chk_mismatch_clr", mm3, 0);
    for (int i = 0; i < 10; i++) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
